// File: rtl/complex_multiplier_stream.sv
// Streaming complex multiplier y = h*x or h*conj(x): three-stage valid/ready pipeline
// with round-half-up scaling, saturation and a sticky overflow flag.
module complex_multiplier_stream #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic                        i_conj,
  input  logic signed [A_WIDTH-1:0]   i_real_h,
  input  logic signed [A_WIDTH-1:0]   i_imag_h,
  input  logic signed [B_WIDTH-1:0]   i_real_x,
  input  logic signed [B_WIDTH-1:0]   i_imag_x,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [OUT_WIDTH-1:0] o_real,
  output logic signed [OUT_WIDTH-1:0] o_imag,
  output logic                        o_sat,
  output logic                        o_sat_sticky,
  input  logic                        i_clr_sat
);

  localparam int P  = A_WIDTH + B_WIDTH;
  localparam int W  = P + 1;
  localparam int R  = W + 1;
  // Combine/round width: never narrower than W+1, and wide enough to sign-extend into the output.
  localparam int CW = (OUT_WIDTH > R) ? OUT_WIDTH : R;

  localparam logic signed [CW-1:0] RND     = (CW'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [CW-1:0] SAT_MAX = CW'({1'b0, {(CW-1){1'b1}}} >> (CW - OUT_WIDTH));
  localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

  logic en;

  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_conj_q, s1_conj_d;
  logic signed [A_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic signed [B_WIDTH-1:0] s1_c_q, s1_c_d, s1_d_q, s1_d_d;

  logic                s2_valid_q, s2_valid_d;
  logic                s2_conj_q, s2_conj_d;
  logic signed [P-1:0] ac_q, ac_d, ad_q, ad_d, bc_q, bc_d, bd_q, bd_d;

  logic                        s3_valid_q, s3_valid_d;
  logic signed [OUT_WIDTH-1:0] real_q, real_d, imag_q, imag_d;
  logic                        sat_q, sat_d;
  logic                        sticky_q, sticky_d;

  logic signed [CW-1:0]  re_full, im_full, re_shift, im_shift;
  logic [OUT_WIDTH:0]    re_sat, im_sat;

  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [CW-1:0] v);
    if (v > SAT_MAX)      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    else if (v < SAT_MIN) return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    else                  return {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  assign en      = !s3_valid_q || i_ready;
  assign o_ready = en;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_conj_d  = s1_conj_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_d_d     = s1_d_q;
    if (en) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_conj_d = i_conj;
        s1_a_d    = i_real_h;
        s1_b_d    = i_imag_h;
        s1_c_d    = i_real_x;
        s1_d_d    = i_imag_x;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_conj_d  = s2_conj_q;
    ac_d       = ac_q;
    ad_d       = ad_q;
    bc_d       = bc_q;
    bd_d       = bd_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_conj_d = s1_conj_q;
        ac_d      = P'(s1_a_q) * P'(s1_c_q);
        ad_d      = P'(s1_a_q) * P'(s1_d_q);
        bc_d      = P'(s1_b_q) * P'(s1_c_q);
        bd_d      = P'(s1_b_q) * P'(s1_d_q);
      end
    end
  end

  always_comb begin
    re_full  = s2_conj_q ? (CW'(ac_q) + CW'(bd_q)) : (CW'(ac_q) - CW'(bd_q));
    im_full  = s2_conj_q ? (CW'(bc_q) - CW'(ad_q)) : (CW'(ad_q) + CW'(bc_q));
    re_shift = (re_full + RND) >>> OUT_SHIFT;
    im_shift = (im_full + RND) >>> OUT_SHIFT;
    re_sat   = saturate(re_shift);
    im_sat   = saturate(im_shift);
  end

  always_comb begin
    s3_valid_d = s3_valid_q;
    real_d     = real_q;
    imag_d     = imag_q;
    sat_d      = sat_q;
    if (en) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        real_d = re_sat[OUT_WIDTH-1:0];
        imag_d = im_sat[OUT_WIDTH-1:0];
        sat_d  = re_sat[OUT_WIDTH] | im_sat[OUT_WIDTH];
      end
    end
    // Sticky includes the sample being loaded so it rises together with o_sat; set beats clear.
    sticky_d = (i_clr_sat ? 1'b0 : sticky_q)
             | (s3_valid_q & sat_q)
             | (en & s2_valid_q & (re_sat[OUT_WIDTH] | im_sat[OUT_WIDTH]));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_conj_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_d_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_conj_q  <= 1'b0;
      ac_q       <= '0;
      ad_q       <= '0;
      bc_q       <= '0;
      bd_q       <= '0;
      s3_valid_q <= 1'b0;
      real_q     <= '0;
      imag_q     <= '0;
      sat_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_conj_q  <= s1_conj_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s1_d_q     <= s1_d_d;
      s2_valid_q <= s2_valid_d;
      s2_conj_q  <= s2_conj_d;
      ac_q       <= ac_d;
      ad_q       <= ad_d;
      bc_q       <= bc_d;
      bd_q       <= bd_d;
      s3_valid_q <= s3_valid_d;
      real_q     <= real_d;
      imag_q     <= imag_d;
      sat_q      <= sat_d;
      sticky_q   <= sticky_d;
    end
  end

  assign o_valid      = s3_valid_q;
  assign o_real       = real_q;
  assign o_imag       = imag_q;
  assign o_sat        = sat_q;
  assign o_sat_sticky = sticky_q;

endmodule

// File: tb/tb_complex_multiplier_stream.sv
// Scoreboard bench for complex_multiplier_stream: directed vectors push expected results,
// an independent monitor pops and compares every delivered output beat.
module tb_complex_multiplier_stream;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_valid;
  logic               o_ready;
  logic               i_conj;
  logic signed [15:0] i_real_h, i_imag_h, i_real_x, i_imag_x;
  logic               o_valid;
  logic               i_ready;
  logic signed [15:0] o_real, o_imag;
  logic               o_sat;
  logic               o_sat_sticky;
  logic               i_clr_sat;

  typedef struct {
    int     re;
    int     im;
    bit     sat;
    bit     sticky;
    bit     lat;
    longint cyc;
  } exp_t;

  exp_t   expQ[$];
  int     testsRun = 0;
  int     testsFailed = 0;
  int     acceptedCount = 0;
  int     sampleIdx = 0;
  longint cyc = 0;

  complex_multiplier_stream #(
    .A_WIDTH(16), .B_WIDTH(16), .OUT_WIDTH(16), .OUT_SHIFT(15)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_conj(i_conj), .i_real_h(i_real_h), .i_imag_h(i_imag_h),
    .i_real_x(i_real_x), .i_imag_x(i_imag_x), .o_valid(o_valid),
    .i_ready(i_ready), .o_real(o_real), .o_imag(o_imag), .o_sat(o_sat),
    .o_sat_sticky(o_sat_sticky), .i_clr_sat(i_clr_sat)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Presents one beat, waits (bounded) for acceptance and records the expected result.
  task automatic applyStimulus(input int hr, input int hi, input int xr, input int xi,
                               input bit cj, input int er, input int ei,
                               input bit es, input bit est, input bit lat);
    exp_t e;
    int   tries = 0;
    i_valid  = 1'b1;
    i_conj   = cj;
    i_real_h = 16'(hr);
    i_imag_h = 16'(hi);
    i_real_x = 16'(xr);
    i_imag_x = 16'(xi);
    @(negedge i_clk);
    while (!o_ready && tries < 50) begin
      tries++;
      @(negedge i_clk);
    end
    if (!o_ready) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept_timeout: o_ready stayed 0 for %0d cycles, required 1", tries);
      i_valid = 1'b0;
      return;
    end
    e.re = er; e.im = ei; e.sat = es; e.sticky = est; e.lat = lat; e.cyc = cyc;
    @(posedge i_clk);
    expQ.push_back(e);
    acceptedCount++;
    #1 i_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("drain_queue_size", expQ.size(), 0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin : monitor
    bit                 prevStall;
    logic signed [15:0] hRe, hIm;
    logic               hSat;
    exp_t               e;
    prevStall = 0;
    hRe = '0; hIm = '0; hSat = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        prevStall = 0;
      end else begin
        if (prevStall) begin
          checkOutput("stall_hold_valid", o_valid, 1);
          checkOutput("stall_hold_real", o_real, hRe);
          checkOutput("stall_hold_imag", o_imag, hIm);
          checkOutput("stall_hold_sat", o_sat, hSat);
        end
        if (o_valid && !i_ready) checkOutput("stall_o_ready", o_ready, 0);
        if (o_valid && i_ready) begin
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_output: got real %0d imag %0d, required no output",
                     o_real, o_imag);
          end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("real[%0d]", sampleIdx), o_real, e.re);
            checkOutput($sformatf("imag[%0d]", sampleIdx), o_imag, e.im);
            checkOutput($sformatf("sat[%0d]", sampleIdx), o_sat, e.sat);
            checkOutput($sformatf("sticky[%0d]", sampleIdx), o_sat_sticky, e.sticky);
            if (e.lat) checkOutput($sformatf("latency[%0d]", sampleIdx), cyc - e.cyc, 3);
            sampleIdx++;
          end
        end
        prevStall = o_valid && !i_ready;
        hRe = o_real; hIm = o_imag; hSat = o_sat;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_conj = 1'b0; i_ready = 1'b1; i_clr_sat = 1'b0;
    i_real_h = '0; i_imag_h = '0; i_real_x = '0; i_imag_x = '0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_o_valid", o_valid, 0);
    checkOutput("reset_o_ready", o_ready, 1);
    checkOutput("reset_o_real", o_real, 0);
    checkOutput("reset_o_imag", o_imag, 0);
    checkOutput("reset_o_sat", o_sat, 0);
    checkOutput("reset_o_sat_sticky", o_sat_sticky, 0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Basic, conjugate and general-value products.
    applyStimulus(16384, 16384, 16384, -16384, 0, 16384, 0, 0, 0, 1);
    applyStimulus(16384, 16384, 16384, -16384, 1, 0, 16384, 0, 0, 0);
    applyStimulus(100, 200, 300, -400, 0, 3, 1, 0, 0, 0);
    applyStimulus(100, 200, 300, -400, 1, -2, 3, 0, 0, 0);

    // Saturation (positive, negative, all-most-negative corner), then a clean sample.
    applyStimulus(-32768, 0, -32768, 0, 0, 32767, 0, 1, 1, 0);
    applyStimulus(-32768, -32768, 32767, -32768, 0, -32768, 1, 1, 1, 0);
    applyStimulus(-32768, -32768, -32768, -32768, 1, 32767, 0, 1, 1, 0);
    applyStimulus(1, 0, 16384, 0, 0, 1, 0, 0, 1, 0);
    waitDrain();
    checkOutput("sticky_before_clr", o_sat_sticky, 1);
    i_clr_sat = 1'b1;
    @(posedge i_clk);
    #1 i_clr_sat = 1'b0;
    checkOutput("sticky_after_clr", o_sat_sticky, 0);

    // Rounding edges.
    applyStimulus(-1, 0, 16384, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 16383, 0, 0, 0, 0, 0, 0, 0);
    waitDrain();

    // Backpressure: 3-cycle i_ready drop in the middle of an 8-sample stream.
    acceptedCount = 0;
    fork
      begin
        for (int k = 1; k <= 8; k++) applyStimulus(k, 0, 32767, 0, 0, k, 0, 0, 0, 0);
      end
      begin
        int n = 0;
        while (acceptedCount < 4 && n < 100) begin
          @(negedge i_clk);
          n++;
        end
        @(posedge i_clk);
        #1 i_ready = 1'b0;
        repeat (3) begin
          @(negedge i_clk);
          checkOutput("bp_o_ready_low", o_ready, 0);
        end
        @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
    join
    waitDrain();

    // Asynchronous reset with three samples in flight (the oldest one saturating).
    applyStimulus(-32768, 0, -32768, 0, 0, 32767, 0, 1, 1, 0);
    applyStimulus(100, 0, 16384, 0, 0, 50, 0, 0, 1, 0);
    applyStimulus(200, 0, 16384, 0, 0, 100, 0, 0, 1, 0);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("midrst_o_valid", o_valid, 0);
    checkOutput("midrst_o_real", o_real, 0);
    checkOutput("midrst_o_imag", o_imag, 0);
    checkOutput("midrst_o_sat", o_sat, 0);
    checkOutput("midrst_o_sat_sticky", o_sat_sticky, 0);
    checkOutput("midrst_o_ready", o_ready, 1);
    expQ.delete();
    @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    applyStimulus(16384, 16384, 16384, -16384, 0, 16384, 0, 0, 0, 1);
    waitDrain();
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("final_queue_size", expQ.size(), 0);
    checkOutput("final_o_valid", o_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/complex_multiplier_stream.md
Name: complex_multiplier_stream

Overview:
- Parametrised, streaming successor to the team's fixed-width pipelined complex multiplier.
- Computes y = h * x, or y = h * conj(x) when conjugate mode is selected, with independent input widths.
- Output is a scaled, round-half-up, saturated result carrying a per-sample overflow flag.
- Uses a valid/ready handshake with full-pipeline backpressure, for the DDFS mixer and correlator paths.

Parameters:
- A_WIDTH, 16: width of signed h operand (real and imag).
- B_WIDTH, 16: width of signed x operand (real and imag).
- OUT_WIDTH, 16: width of signed output real and imag.
- OUT_SHIFT, 15: arithmetic right shift applied to the full-precision result, 0..A_WIDTH+B_WIDTH.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept; combinational: !stage3_valid | i_ready.
- i_conj  in  1  1 = multiply by conj(x); sampled with the input beat.
- i_real_h  in  A_WIDTH  signed Re(h).
- i_imag_h  in  A_WIDTH  signed Im(h).
- i_real_x  in  B_WIDTH  signed Re(x).
- i_imag_x  in  B_WIDTH  signed Im(x).
- o_valid  out  1  output sample valid.
- i_ready  in  1  downstream accepts output.
- o_real  out  OUT_WIDTH  signed Re(y).
- o_imag  out  OUT_WIDTH  signed Im(y).
- o_sat  out  1  this output sample saturated in real or imag.
- o_sat_sticky  out  1  OR of all o_sat since reset or i_clr_sat.
- i_clr_sat  in  1  synchronous clear of o_sat_sticky.

Behaviour:
- Reset:
  - i_rst_n low asynchronously clears all valid bits, all data registers, o_real, o_imag, o_sat and o_sat_sticky to 0.
  - In-flight samples are discarded.
  - o_ready is 1 after reset.
- Pipeline: 3 stages, global enable en = !stage3_valid | i_ready.
  - S1: register inputs and conj flag.
  - S2: four products ac, ad, bc, bd, each A_WIDTH+B_WIDTH bits (a=Re h, b=Im h, c=Re x, d=Im x).
  - S3: combine, round, saturate, register outputs.
- Latency: 3 cycles from the accepted beat (i_valid & o_ready) to o_valid, assuming no stall.
- Throughput: one sample per clock when i_ready is held high.
- Stall: when en=0, every stage holds, and o_real, o_imag, o_sat and o_valid stay stable. No sample is lost or duplicated, and order is preserved.
- Bubbles: valid bits propagate with the data. A bubble in S1 or S2 advances whenever en=1.
- Combine, at full width W = A_WIDTH+B_WIDTH+1:
  - conj=0: re = ac - bd, im = ad + bc.
  - conj=1: re = ac + bd, im = bc - ad.
- Rounding, only when OUT_SHIFT>0: add 2^(OUT_SHIFT-1), then arithmetic shift right by OUT_SHIFT. This is round-half-up, so ties go toward +inf.
- Rounding is done at W+1 bits so the addition cannot wrap.
- Saturation:
  - If the shifted value is outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], clamp to the nearest limit and set o_sat for that sample.
  - If OUT_WIDTH is at least the shifted width, sign-extend and never saturate.
- o_sat is valid only with o_valid.
- o_sat_sticky sets on any o_valid & o_sat beat.
- If i_clr_sat and a saturating beat occur in the same cycle, set wins.
- i_conj is per-sample, so mode changes take effect on the next accepted beat with no pipeline flush.
- Corner case: the most negative value on all operands (e.g. -32768 * -32768 * 2 = 2^31) must not wrap at width W.

Test Plan:
- Basic, defaults, conj=0: h=16384+16384j, x=16384-16384j → after 3 cycles o_real=16384, o_imag=0, o_sat=0.
- Conjugate, same operands with conj=1: re = 2^28 - 2^28 → o_real=0; im = 2^28 + 2^28 → o_imag=16384.
- Saturation: h=-32768+0j, x=-32768+0j → o_real=32767, o_imag=0, o_sat=1, o_sat_sticky=1. Next normal sample gives o_sat=0 with sticky still 1. Pulsing i_clr_sat clears sticky.
- Rounding:
  - h=1+0j, x=16384+0j → o_real=1 (tie rounds up).
  - h=-1+0j, x=16384+0j → o_real=0.
  - h=1+0j, x=16383+0j → o_real=0.
- Backpressure: stream 8 samples with incrementing h real (1..8, x=32767), drop i_ready for 3 cycles mid-stream → o_ready low during the stall, outputs held stable, all 8 results delivered in order with none duplicated.
- Reset mid-stream: assert i_rst_n low asynchronously between clock edges with 3 samples in flight → o_valid=0 and outputs 0 immediately. After release, no stale samples appear and the first new sample emerges with 3-cycle latency.
